// File: rtl/dnn_acc_pkg.sv
// Shared types and default constants for the divider-fed accelerator sequencing blocks.
package dnn_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } seq_state_t;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned WDOG_CYCLES_DEF = 64;
   localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/edge_sync_detect.sv
// Multi-flop synchroniser for an asynchronous level plus a rising-edge detector.
module edge_sync_detect
   import dnn_acc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clock_in,
   input  logic reset_n,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/slow_tick_sequencer.sv
// Turns a divided clock into fast-domain ticks and sequences N accelerator steps on them,
// with start/busy/done handshake, abort and a stall watchdog.
module slow_tick_sequencer
   import dnn_acc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             slow_clk_in,
   input  logic             start,
   input  logic [CNT_W-1:0] num_steps,
   input  logic             abort,
   output logic             tick,
   output logic             step_en,
   output logic [CNT_W-1:0] step_idx,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned WdogW = $clog2(WDOG_CYCLES);
   localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] step_idx_q, step_idx_d;
   logic [WdogW-1:0] wdog_q, wdog_d;
   logic             step_en_q, step_en_d;
   logic             tick_q;
   logic             done_q;
   logic             rise;

   edge_sync_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_edge_sync_detect (
      .clock_in(clock_in),
      .reset_n (reset_n),
      .async_in(slow_clk_in),
      .rise    (rise)
   );

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      step_idx_d = step_idx_q;
      wdog_d     = wdog_q;
      step_en_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // start beats a simultaneous abort simply because abort is not looked at here
            if (start) begin
               if (num_steps == '0) begin
                  state_d = DONE;
               end else begin
                  n_d     = num_steps;
                  cnt_d   = '0;
                  wdog_d  = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (rise) begin
               step_en_d  = 1'b1;
               step_idx_d = cnt_q;
               cnt_d      = cnt_q + 1'b1;
               wdog_d     = '0;
               if (cnt_q == n_q - 1'b1) state_d = DONE;
            end else if (wdog_q == WdogLast) begin
               state_d = ERR;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
         ERR: begin
            if (abort) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         cnt_q      <= '0;
         step_idx_q <= '0;
         wdog_q     <= '0;
         step_en_q  <= 1'b0;
         tick_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         step_idx_q <= step_idx_d;
         wdog_q     <= wdog_d;
         step_en_q  <= step_en_d;
         tick_q     <= rise;
         // Registered so the completion pulse lands the cycle after the final step_en
         done_q     <= (state_q == DONE);
      end
   end

   assign tick     = tick_q;
   assign step_en  = step_en_q;
   assign step_idx = step_idx_q;
   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign err      = (state_q == ERR);

endmodule

// File: tb/tb_slow_tick_sequencer.sv
// Scoreboard bench: stimulus queues expected step/done/err events with their cycle stamps,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_slow_tick_sequencer;

   localparam int unsigned CNT_W = 16;
   localparam int EvStep = 0;
   localparam int EvDone = 1;
   localparam int EvErr  = 2;

   typedef struct {
      int kind;
      int idx;
      int cyc;
   } ev_t;

   logic             clock_in = 1'b0;
   logic             reset_n  = 1'b0;
   logic             slow_clk_in = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_steps = '0;
   logic             abort = 1'b0;
   logic             tick, step_en, busy, done, err;
   logic [CNT_W-1:0] step_idx;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_err = 0;
   bit  mon_en = 1'b0;
   ev_t exp_q[$];

   slow_tick_sequencer #(
      .SYNC_STAGES(2),
      .CNT_W      (CNT_W),
      .WDOG_CYCLES(64)
   ) dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .slow_clk_in(slow_clk_in),
      .start      (start),
      .num_steps  (num_steps),
      .abort      (abort),
      .tick       (tick),
      .step_en    (step_en),
      .step_idx   (step_idx),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial forever #5 clock_in = ~clock_in;

   always @(posedge clock_in) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int idx, input int at);
      ev_t e;
      e.kind = kind;
      e.idx  = idx;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic match_ev(input int kind, input int idx);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind %0d idx %0d at cycle %0d, expected none",
                  kind, idx, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.idx != idx || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event: got kind %0d idx %0d cycle %0d expected kind %0d idx %0d cycle %0d",
                     kind, idx, cyc, e.kind, e.idx, e.cyc);
         end
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   initial begin
      logic err_prev;
      ev_t  e;
      err_prev = 1'b0;
      forever begin
         @(negedge clock_in);
         if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               n_cmp++;
               n_err++;
               $display("FAIL missing_event: kind %0d idx %0d expected at cycle %0d, now %0d",
                        e.kind, e.idx, e.cyc, cyc);
            end
            if (step_en) match_ev(EvStep, int'(step_idx));
            if (done) match_ev(EvDone, 0);
            if (err && !err_prev) match_ev(EvErr, 0);
         end
         err_prev = err;
      end
   end

   // One slow_clk_in period of 16 fast cycles; the step (if any) shows 3 edges after the rise.
   task automatic rise_once(input bit push_step, input int idx, input bit last);
      int c;
      c = cyc;
      slow_clk_in = 1'b1;
      if (push_step) push_ev(EvStep, idx, c + 3);
      if (last) push_ev(EvDone, 0, c + 4);
      repeat (8) @(negedge clock_in);
      slow_clk_in = 1'b0;
      repeat (8) @(negedge clock_in);
   endtask

   task automatic pulse_start(input int n);
      start     = 1'b1;
      num_steps = CNT_W'(n);
      @(negedge clock_in);
      start = 1'b0;
   endtask

   initial begin
      int c;
      // Reset and synchroniser latency
      repeat (3) @(negedge clock_in);
      check("rst_tick", int'(tick), 0);
      check("rst_step_en", int'(step_en), 0);
      check("rst_step_idx", int'(step_idx), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      reset_n     = 1'b1;
      mon_en      = 1'b1;
      slow_clk_in = 1'b1;
      @(negedge clock_in);
      check("lat_tick_e1", int'(tick), 0);
      @(negedge clock_in);
      check("lat_tick_e2", int'(tick), 0);
      @(negedge clock_in);
      check("lat_tick_e3", int'(tick), 1);
      @(negedge clock_in);
      check("lat_tick_e4", int'(tick), 0);
      slow_clk_in = 1'b0;
      repeat (8) @(negedge clock_in);
      check("fall_no_tick", int'(tick), 0);

      // Normal run, N=4
      pulse_start(4);
      check("run_busy", int'(busy), 1);
      for (int i = 0; i < 4; i++) rise_once(1'b1, i, i == 3);
      check("run_busy_end", int'(busy), 0);
      check("run_idx_hold", int'(step_idx), 3);

      // Zero steps
      c = cyc;
      start     = 1'b1;
      num_steps = '0;
      push_ev(EvDone, 0, c + 2);
      @(negedge clock_in);
      start = 1'b0;
      check("zero_busy_a", int'(busy), 0);
      @(negedge clock_in);
      check("zero_busy_b", int'(busy), 0);
      repeat (4) @(negedge clock_in);

      // Abort coinciding with the 4th rise
      pulse_start(10);
      for (int i = 0; i < 3; i++) rise_once(1'b1, i, 1'b0);
      slow_clk_in = 1'b1;
      repeat (2) @(negedge clock_in);
      abort = 1'b1;
      @(negedge clock_in);
      abort = 1'b0;
      check("abort_tick", int'(tick), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_idx", int'(step_idx), 2);
      repeat (6) @(negedge clock_in);
      slow_clk_in = 1'b0;
      repeat (10) @(negedge clock_in);

      // Watchdog with slow_clk_in held low
      c = cyc;
      push_ev(EvErr, 0, c + 65);
      pulse_start(5);
      repeat (70) @(negedge clock_in);
      check("wdog_err", int'(err), 1);
      rise_once(1'b0, 0, 1'b0);
      pulse_start(2);
      repeat (2) @(negedge clock_in);
      check("err_start_ignored", int'(err), 1);
      check("err_busy", int'(busy), 0);
      abort = 1'b1;
      @(negedge clock_in);
      abort = 1'b0;
      check("err_cleared", int'(err), 0);
      repeat (4) @(negedge clock_in);

      // Busy lockout: restarts with N=7 during RUN are ignored
      pulse_start(3);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) pulse_start(7);
         rise_once(1'b1, i, i == 2);
      end
      check("lock_busy_end", int'(busy), 0);
      repeat (20) @(negedge clock_in);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/slow_tick_sequencer.md
Name: slow_tick_sequencer

Overview:
- Sits directly downstream of the clock divider.
- Takes the divided clock as a plain data input and never uses it as a clock.
- Synchronises it into the fast clock_in domain and turns each rising edge into a one-cycle tick.
- Uses those ticks to sequence a programmed number of accelerator steps with a start/busy/done handshake, an abort input and a stall watchdog.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on slow_clk_in (legal value ≥2).
- CNT_W, 16, width of num_steps, step_idx and the step counter.
- WDOG_CYCLES, 64, clock_in cycles allowed between ticks in RUN before ERR (legal value ≥2).

Ports:
- clock_in, input, 1, fast system clock; all flops on its rising edge.
- reset_n, input, 1, synchronous active-low reset.
- slow_clk_in, input, 1, divided clock from the divider; treated as asynchronous.
- start, input, 1, begin sequence; sampled only in IDLE.
- num_steps, input, CNT_W, step count; latched when start is accepted.
- abort, input, 1, cancel an active or errored sequence.
- tick, output, 1, one-cycle pulse per synchronised rising edge of slow_clk_in, in every state.
- step_en, output, 1, one-cycle pulse per executed step.
- step_idx, output, CNT_W, index of the current/last step.
- busy, output, 1, high while state==RUN.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, watchdog error flag.

Behaviour:
- Reset: reset_n low at a clock_in edge clears everything. Synchroniser flops, edge-history flop, counters and all outputs go to 0; state goes to IDLE. Reset mid-sequence discards it with no done.
- Edge detect:
  - sync[0] samples slow_clk_in; the last stage is s.
  - prev is s delayed one cycle; rise = s & ~prev.
  - tick is registered rise.
  - Latency: tick is high exactly SYNC_STAGES+1 edges after the first edge that samples slow_clk_in high, for one cycle.
  - A falling edge produces nothing.
- States (binary encoded): IDLE, RUN, DONE, ERR.
- IDLE:
  - start with num_steps==0 → DONE; no step_en.
  - start with num_steps>0 → latch N=num_steps, cnt←0, wdog←0, then RUN.
- RUN, in priority order:
  1. abort → IDLE; no done, no step_en that cycle.
  2. rise → step_en←1, step_idx←cnt, cnt←cnt+1, wdog←0. If cnt==N-1, go to DONE.
  3. wdog==WDOG_CYCLES-1 → ERR.
  4. Otherwise wdog←wdog+1.
- Watchdog timing: if slow_clk_in never toggles, ERR is entered on the WDOG_CYCLES-th edge after entering RUN.
- DONE: done=1 for exactly one cycle (decoded from registered state), then IDLE. For N>0, done rises the cycle after the final step_en.
- ERR: err=1 while in ERR. Ticks still pulse; step_en stays 0. abort → IDLE (err clears next cycle). start is ignored.
- Handshake:
  - start is ignored unless state==IDLE; no queuing.
  - start and abort together in IDLE: start wins, abort is ignored.
- Width rules:
  - cnt and step_idx are CNT_W unsigned.
  - N=2^CNT_W-1 is legal; cnt never wraps because the sequence ends at N-1.
  - step_idx holds its last value after DONE, ERR or abort until the next step_en or reset.
- busy is combinationally decoded from registered state (state==RUN); no input-to-output combinational paths.

Decomposition:
- Shared package (dnn_acc_pkg):
  - seq_state_t enum {IDLE, RUN, DONE, ERR}.
  - Default constants SYNC_STAGES_DEF and WDOG_CYCLES_DEF.
- One natural sub-module: edge_sync_detect (parameter SYNC_STAGES; ports clock_in, reset_n, async_in, rise).
  - Reusable for other divider-fed inputs.
  - The sequencer instantiates it once and registers tick from its rise output.

Test Plan:
- Reset/latency: hold reset_n=0 for 3 cycles → all outputs 0. Raise slow_clk_in once → tick high exactly 3 edges later for 1 cycle, with SYNC_STAGES=2.
- Normal run: num_steps=4, start pulse, slow_clk_in period 16 clock_in cycles → busy high; 4 step_en pulses with step_idx 0,1,2,3; done one cycle after the 4th step_en; busy low.
- Zero steps: num_steps=0, start → done next cycle, no step_en, busy never high.
- Abort: num_steps=10, abort after the 3rd step_en, raised in the same cycle as a rise → no step_en that cycle, IDLE, no done, step_idx=2.
- Watchdog: num_steps=5, slow_clk_in held low after start, WDOG_CYCLES=64 → err high exactly 64 edges after entering RUN. Ticks injected in ERR give no step_en. abort → err low next cycle. start while err=1 is ignored.
- Busy lockout: start pulsed repeatedly during RUN with different num_steps → ignored; the original N completes unchanged.
